// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_responder
// Description : Responder for the CPU data-memory port. Decodes the byte
//               address into a word RAM and a small MMIO block (output data
//               register, status, overflow clear). Words stored to the output
//               data register are queued in a FIFO and drained over a
//               valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        overflow
);

    localparam int c_RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;

    // Word addresses (byte address >> 2) of the MMIO registers
    localparam logic [29:0] c_WA_OUT    = 30'h040;
    localparam logic [29:0] c_WA_STATUS = 30'h041;
    localparam logic [29:0] c_WA_CLEAR  = 30'h042;

    logic [31:0]         r_ram  [RAM_WORDS];
    logic [31:0]         r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;

    logic [29:0]         w_word;
    logic [c_RAM_AW-1:0] w_ram_idx;
    logic                w_sel_ram;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push_req;
    logic                w_push;
    logic                w_reject;
    logic                w_clear;
    logic [31:0]         w_status;
    logic                w_unused_addr;

    // Byte offset within the word is ignored: misaligned accesses hit the word
    assign w_unused_addr = &{1'b0, a[1:0]};
    assign w_word        = a[31:2];
    assign w_ram_idx     = a[2 +: c_RAM_AW];
    assign w_sel_ram     = (a[31:8] == 24'd0);

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop      = !w_empty && out_ready;
    // Reset masks CPU side effects on the FIFO and the clear register
    assign w_push_req = we && (w_word == c_WA_OUT) && !reset;
    // A full FIFO still takes a push when the head leaves on the same edge
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_reject   = w_push_req && !w_push;
    assign w_clear    = we && (w_word == c_WA_CLEAR) && !reset;

    assign w_status = {24'd0, r_overflow, w_full, w_empty, 5'(r_count)};

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? 32'd0 : r_fifo[r_rptr];
    assign overflow  = r_overflow;

    // RAM write port; deliberately unaffected by reset so data survives it
    always_ff @(posedge clk) begin
        if (we && w_sel_ram) begin
            r_ram[w_ram_idx] <= wd;
        end
    end

    // FIFO storage write at the current write pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= wd;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_reject) begin
                r_overflow <= 1'b1;
            end else if (w_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Zero-latency read mux; reflects state as of the last clock edge
    always_comb begin
        rd = 32'd0;
        if (w_sel_ram) begin
            rd = r_ram[w_ram_idx];
        end else if (w_word == c_WA_STATUS) begin
            rd = w_status;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_mmio_responder
// Description : Self-checking bench for dmem_mmio_responder. Directed vector
//               table, hand-written multi-cycle sequences and a randomized
//               phase, all checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio_responder;

    localparam int RW = 64;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array, queue and a flag
    logic [31:0] m_ram [RW];
    logic [31:0] m_q [$];
    bit          m_ovf;

    typedef struct {
        bit          rst;
        bit          w;
        logic [31:0] ad;
        logic [31:0] d;
        bit          rdy;
        logic [31:0] e_rd;
        bit          e_v;
        logic [31:0] e_d;
        bit          e_o;
    } vec_t;

    vec_t tbl [$];

    dmem_mmio_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .a         (a),
        .wd        (wd),
        .rd        (rd),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [31:0] ad);
        logic [31:0] s;
        s = 32'd0;
        if (ad[31:8] == 24'd0) begin
            s = m_ram[int'(ad[7:2]) % RW];
        end else if (ad[31:2] == 30'h041) begin
            s[7]   = m_ovf;
            s[6]   = (m_q.size() == FD);
            s[5]   = (m_q.size() == 0);
            s[4:0] = 5'(m_q.size());
        end
        return s;
    endfunction

    // Advance the model across one clock edge with the given inputs
    task automatic m_step(input bit r, input bit w, input logic [31:0] ad,
                          input logic [31:0] d, input bit rdy);
        bit pop;
        bit full;
        if (w && ad[31:8] == 24'd0) m_ram[int'(ad[7:2]) % RW] = d;
        if (r) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            pop  = (m_q.size() != 0) && rdy;
            full = (m_q.size() == FD);
            if (pop) void'(m_q.pop_front());
            if (w && ad[31:2] == 30'h040) begin
                if (!full || pop) m_q.push_back(d);
                else              m_ovf = 1'b1;
            end
            if (w && ad[31:2] == 30'h042) m_ovf = 1'b0;
        end
    endtask

    // One cycle: drive, check against model (and optional fixed expectations), clock
    task automatic cycle(input bit r, input bit w, input logic [31:0] ad, input logic [31:0] d,
                         input bit rdy, input bit hx, input logic [31:0] erd, input bit ev,
                         input logic [31:0] ed, input bit eo);
        reset = r; we = w; a = ad; wd = d; out_ready = rdy;
        #2;
        chk("rd_model",    rd,              m_rd(ad));
        chk("valid_model", 32'(out_valid),  32'(m_q.size() != 0));
        chk("data_model",  out_data,        (m_q.size() != 0) ? m_q[0] : 32'd0);
        chk("ovf_model",   32'(overflow),   32'(m_ovf));
        if (hx) begin
            chk("rd_exp",    rd,             erd);
            chk("valid_exp", 32'(out_valid), 32'(ev));
            chk("data_exp",  out_data,       ed);
            chk("ovf_exp",   32'(overflow),  32'(eo));
        end
        @(posedge clk);
        m_step(r, w, ad, d, rdy);
        #1;
    endtask

    task automatic add(input bit w, input logic [31:0] ad, input logic [31:0] d, input bit rdy,
                       input logic [31:0] erd, input bit ev, input logic [31:0] ed, input bit eo);
        vec_t v;
        v.rst = 1'b0; v.w = w; v.ad = ad; v.d = d; v.rdy = rdy;
        v.e_rd = erd; v.e_v = ev; v.e_d = ed; v.e_o = eo;
        tbl.push_back(v);
    endtask

    initial begin
        // Directed vectors: reset state, RAM path, fill/overflow, clear, unmapped
        add(0, 32'h104, 0, 0, 32'h20, 0, 0, 0);
        add(1, 32'h000, 32'h000000A1, 0, 32'h10000000, 0, 0, 0);
        add(1, 32'h004, 32'h0000005A, 0, 32'h10000001, 0, 0, 0);
        add(1, 32'h0FC, 32'hDEADBEEF, 0, 32'h1000003F, 0, 0, 0);
        add(0, 32'h000, 0, 0, 32'h000000A1, 0, 0, 0);
        add(0, 32'h004, 0, 0, 32'h0000005A, 0, 0, 0);
        add(0, 32'h0FC, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        add(0, 32'h003, 0, 0, 32'h000000A1, 0, 0, 0);
        add(1, 32'h000, 32'h12345678, 0, 32'h000000A1, 0, 0, 0);
        add(0, 32'h000, 0, 0, 32'h12345678, 0, 0, 0);
        add(1, 32'h100, 32'h11, 0, 0, 0, 0, 0);
        add(1, 32'h100, 32'h22, 0, 0, 1, 32'h11, 0);
        add(1, 32'h100, 32'h33, 0, 0, 1, 32'h11, 0);
        add(1, 32'h100, 32'h44, 0, 0, 1, 32'h11, 0);
        add(1, 32'h100, 32'h55, 0, 0, 1, 32'h11, 0);
        add(0, 32'h104, 0, 0, 32'hC4, 1, 32'h11, 1);
        add(0, 32'h104, 0, 1, 32'hC4, 1, 32'h11, 1);
        add(0, 32'h104, 0, 1, 32'h83, 1, 32'h22, 1);
        add(0, 32'h104, 0, 1, 32'h82, 1, 32'h33, 1);
        add(0, 32'h104, 0, 1, 32'h81, 1, 32'h44, 1);
        add(0, 32'h104, 0, 1, 32'hA0, 0, 0, 1);
        add(1, 32'h108, 0, 0, 0, 0, 0, 1);
        add(0, 32'h104, 0, 0, 32'h20, 0, 0, 0);
        add(1, 32'h104, 32'hFFFF, 0, 32'h20, 0, 0, 0);
        add(1, 32'h200, 32'hFFFF, 0, 0, 0, 0, 0);
        add(0, 32'h200, 0, 0, 0, 0, 0, 0);
        add(0, 32'h100, 0, 0, 0, 0, 0, 0);
        add(0, 32'h108, 0, 0, 0, 0, 0, 0);
        add(0, 32'h104, 0, 0, 32'h20, 0, 0, 0);

        reset = 1'b1; we = 1'b0; a = 32'd0; wd = 32'd0; out_ready = 1'b0;
        foreach (m_ram[i]) m_ram[i] = 32'd0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Preload every RAM word with a known pattern (during reset, which RAM ignores)
        for (int i = 0; i < RW; i++) begin
            reset = 1'b1; we = 1'b1; a = 32'(i * 4); wd = 32'h10000000 + 32'(i);
            @(posedge clk);
            m_step(1'b1, 1'b1, 32'(i * 4), 32'h10000000 + 32'(i), 1'b0);
            #1;
        end

        foreach (tbl[i])
            cycle(tbl[i].rst, tbl[i].w, tbl[i].ad, tbl[i].d, tbl[i].rdy, 1'b1,
                  tbl[i].e_rd, tbl[i].e_v, tbl[i].e_d, tbl[i].e_o);

        // In-order stream with consumer always ready; no fall-through
        cycle(0, 1, 32'h100, 2, 1, 1, 0, 0, 0, 0);
        cycle(0, 1, 32'h100, 1, 1, 1, 0, 1, 2, 0);
        cycle(0, 1, 32'h100, 0, 1, 1, 0, 1, 1, 0);
        cycle(0, 0, 32'h104, 0, 1, 1, 32'h01, 1, 0, 0);
        cycle(0, 0, 32'h104, 0, 1, 1, 32'h20, 0, 0, 0);

        // Full FIFO with simultaneous push and pop; pointers wrap
        cycle(0, 1, 32'h100, 1, 0, 1, 0, 0, 0, 0);
        cycle(0, 1, 32'h100, 2, 0, 1, 0, 1, 1, 0);
        cycle(0, 1, 32'h100, 3, 0, 1, 0, 1, 1, 0);
        cycle(0, 1, 32'h100, 4, 0, 1, 0, 1, 1, 0);
        cycle(0, 1, 32'h100, 5, 1, 1, 0, 1, 1, 0);
        cycle(0, 0, 32'h104, 0, 0, 1, 32'h44, 1, 2, 0);
        cycle(0, 0, 32'h104, 0, 1, 1, 32'h44, 1, 2, 0);
        cycle(0, 0, 32'h104, 0, 1, 1, 32'h03, 1, 3, 0);
        cycle(0, 0, 32'h104, 0, 1, 1, 32'h02, 1, 4, 0);
        cycle(0, 0, 32'h104, 0, 1, 1, 32'h01, 1, 5, 0);
        cycle(0, 0, 32'h104, 0, 1, 1, 32'h20, 0, 0, 0);

        // Reset mid-operation discards the queue but not RAM, and masks the push
        cycle(0, 1, 32'h004, 7, 0, 1, 32'h5A, 0, 0, 0);
        cycle(0, 1, 32'h100, 32'hA, 0, 1, 0, 0, 0, 0);
        cycle(0, 1, 32'h100, 32'hB, 0, 1, 0, 1, 32'hA, 0);
        cycle(0, 1, 32'h100, 32'hC, 0, 1, 0, 1, 32'hA, 0);
        cycle(0, 1, 32'h100, 32'hD, 0, 1, 0, 1, 32'hA, 0);
        cycle(0, 1, 32'h100, 32'hE, 0, 1, 0, 1, 32'hA, 0);
        cycle(1, 1, 32'h100, 9, 0, 1, 0, 1, 32'hA, 1);
        cycle(0, 0, 32'h104, 0, 1, 1, 32'h20, 0, 0, 0);
        cycle(0, 0, 32'h004, 0, 0, 1, 7, 0, 0, 0);
        cycle(1, 1, 32'h008, 32'h33, 0, 1, 32'h10000002, 0, 0, 0);
        cycle(0, 0, 32'h008, 0, 0, 1, 32'h33, 0, 0, 0);

        // Randomized traffic checked against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ad;
            int sel;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       ad = {24'd0, 8'($urandom_range(0, 255))};
                1, 6, 7: ad = 32'h100 | 32'($urandom_range(0, 3));
                2:       ad = 32'h104;
                3:       ad = 32'h108;
                4:       ad = 32'h200;
                default: ad = $urandom;
            endcase
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, ad, $urandom,
                  $urandom_range(0, 2) == 0, 0, 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
